cdc_handshake_bus: RTL and testbench
====================================

Name: cdc_handshake_bus

Overview:
- Parametrised multi-bit clock-domain crossing from clk_a to clk_b using a toggle-based req/ack handshake. Generalises the enable-synchronised 4-bit crossing with configurable width and synchroniser depth.
- Adds backpressure on both sides: valid/ready on source and destination.
- Sits between any clk_a producer and clk_b consumer. Guarantees one source word produces exactly one destination word, with no loss or duplication.

Parameters:
- DATA_W, 4, payload width in bits (>=1).
- SYNC_STAGES, 2, flops per synchroniser chain (>=2).

Ports:
- clk_a  input  1  source-domain clock
- arstn  input  1  source-domain reset, asynchronous, active-low
- clk_b  input  1  destination-domain clock
- brstn  input  1  destination-domain reset, asynchronous, active-low
- src_data  input  DATA_W  source payload
- src_valid  input  1  source offers src_data
- src_ready  output  1  block can accept a word (clk_a domain)
- dst_data  output  DATA_W  captured payload (clk_b domain)
- dst_valid  output  1  dst_data holds an unconsumed word
- dst_ready  input  1  consumer accepts dst_data
- src_busy  output  1  a transfer is in flight (inverse of src_ready)

Behaviour:
- Reset:
  - Interface: reset arstn, asynchronous, active-low; clock clk_a. clk_b logic resets on brstn, asynchronous, active-low.
  - Reset values: src_ready=1, src_busy=0, dst_valid=0, dst_data=0. Hold register, req_tgl, ack_tgl and all sync flops reset to 0.
- Source FSM (clk_a), states S_IDLE and S_WAIT:
  - S_IDLE: src_ready=1.
  - On src_valid && src_ready: hold_reg<=src_data, req_tgl<=~req_tgl, go to S_WAIT.
  - S_WAIT: src_ready=0. hold_reg is frozen and must not change.
  - Exit S_WAIT when ack_sync==req_tgl, returning to S_IDLE on that edge.
  - src_valid while src_ready=0 is ignored; the producer must hold src_valid and src_data.
- Destination FSM (clk_b), states D_EMPTY and D_FULL:
  - req_tgl passes through SYNC_STAGES flops into req_s. A delay flop req_d gives req_edge = req_s ^ req_d.
  - D_EMPTY with req_edge: dst_data<=hold_reg (stable by construction), dst_valid<=1, go to D_FULL.
  - D_FULL with dst_ready: dst_valid<=0, ack_tgl<=~ack_tgl, go to D_EMPTY.
  - dst_valid and dst_data stay stable while dst_valid=1 and dst_ready=0.
  - dst_ready while dst_valid=0 has no effect.
- Ack path: ack_tgl passes through SYNC_STAGES clk_a flops into ack_sync.
- Only hold_reg crosses as multi-bit data. It is sampled only after the req toggle is synchronised, so no bit-skew is possible.
- Latency:
  - Source accept at clk_a edge N, then dst_valid=1 after SYNC_STAGES+1 clk_b rising edges.
  - Destination accept at clk_b edge M, then src_ready=1 after SYNC_STAGES+1 clk_a rising edges.
  - Throughput is at most one word per full round trip.
- Boundaries:
  - req_edge is only ever seen in D_EMPTY, because the source cannot issue a new toggle until ack returns.
  - src_valid held high continuously: the next word is accepted on the first S_IDLE cycle; no gaps are added beyond the handshake.
  - dst_ready tied high: dst_valid is a 1-cycle pulse per word.
  - Equal or unrelated clock frequencies are both legal. No ratio constraint applies.
  - Reset mid-transfer: arstn and brstn are required to overlap (system rule).
  - Under an overlapping reset, the in-flight word is discarded, both FSMs return to their idle states, and no spurious dst_valid follows reset release.
  - Single-domain reset is unsupported. Assertions flag it in simulation.
- Width rule: payload is passed bit-exact. No zero/sign extension is applied.

Decomposition:
- Package cdc_handshake_pkg holds:
  - source state enum {S_IDLE, S_WAIT}
  - destination state enum {D_EMPTY, D_FULL}
  - MIN_SYNC_STAGES=2, used by an elaboration check on SYNC_STAGES.
- Sub-module cdc_sync_bit is a SYNC_STAGES-deep single-bit synchroniser with its own clock and async active-low reset. It is instantiated twice: req into clk_b, ack into clk_a.

Test Plan:
- Reset release, then idle 20 cycles -> src_ready=1, dst_valid=0, dst_data=0, no dst_valid pulse.
- DATA_W=4, single word 4'hA, clk_a=100MHz, clk_b=37MHz, dst_ready=1 -> exactly one dst_valid pulse with dst_data=4'hA, 3 clk_b edges after accept. src_ready returns 3 clk_a edges after the dst accept.
- DATA_W=16, stream 0x0000..0x00FF with src_valid held high and random dst_ready -> scoreboard sees 256 in-order words, no duplicates or drops.
- dst_ready=0 for 50 clk_b cycles after dst_valid -> dst_data stable; src_ready stays 0 throughout; src_valid toggling has no effect.
- SYNC_STAGES=3, clk_b faster than clk_a (250MHz vs 50MHz) -> latency 4 edges each way; data matches.
- Assert arstn and brstn together while in S_WAIT / D_FULL with word 0x5 -> after release, src_ready=1, dst_valid=0. The next word 0x6 is delivered correctly and 0x5 never appears.

Source files
------------

// File: rtl/cdc_handshake_pkg.sv
// Shared types and limits for the toggle-handshake clock-domain crossing.
package cdc_handshake_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 32'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } src_state_e;

  typedef enum logic {
    D_EMPTY = 1'b0,
    D_FULL  = 1'b1
  } dst_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module cdc_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_bus.sv
// Multi-bit clk_a -> clk_b crossing: a frozen hold register is published by a
// req toggle and released by an ack toggle, with valid/ready on both sides.
module cdc_handshake_bus
  import cdc_handshake_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_a,
  input  logic              arstn,
  input  logic              clk_b,
  input  logic              brstn,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_valid,
  input  logic              dst_ready,
  output logic              src_busy
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("cdc_handshake_bus: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end
  if (DATA_W < 32'd1) begin : g_bad_width
    $error("cdc_handshake_bus: DATA_W must be at least 1");
  end

  src_state_e        src_state_r, src_state_s;
  logic              src_load_s;
  logic              req_tgl_r;
  logic              ack_sync_s;
  logic              src_ready_r;
  logic              src_busy_r;
  logic [DATA_W-1:0] hold_r;

  dst_state_e        dst_state_r, dst_state_s;
  logic              dst_load_s;
  logic              dst_pop_s;
  logic              req_s;
  logic              req_d_r;
  logic              req_edge_s;
  logic              ack_tgl_r;
  logic              dst_valid_r;
  logic [DATA_W-1:0] dst_data_r;

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk  (clk_b),
    .rstn (brstn),
    .d    (req_tgl_r),
    .q    (req_s)
  );

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk  (clk_a),
    .rstn (arstn),
    .d    (ack_tgl_r),
    .q    (ack_sync_s)
  );

  // source next state: accept in idle, wait until ack toggle matches req toggle
  always_comb begin
    src_state_s = src_state_r;
    src_load_s  = 1'b0;
    case (src_state_r)
      S_IDLE: begin
        if (src_valid) begin
          src_load_s  = 1'b1;
          src_state_s = S_WAIT;
        end else begin
          src_state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (ack_sync_s == req_tgl_r) begin
          src_state_s = S_IDLE;
        end else begin
          src_state_s = S_WAIT;
        end
      end
      default: src_state_s = S_IDLE;
    endcase
  end

  // source registers; hold_r only loads on accept, so it is frozen in S_WAIT
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      src_state_r <= S_IDLE;
      src_ready_r <= 1'b1;
      src_busy_r  <= 1'b0;
      req_tgl_r   <= 1'b0;
      hold_r      <= '0;
    end else begin
      src_state_r <= src_state_s;
      src_ready_r <= (src_state_s == S_IDLE);
      src_busy_r  <= (src_state_s == S_WAIT);
      if (src_load_s) begin
        hold_r    <= src_data;
        req_tgl_r <= ~req_tgl_r;
      end
    end
  end

  assign req_edge_s = req_s ^ req_d_r;

  // destination next state: capture on a req edge, release on consumer ready
  always_comb begin
    dst_state_s = dst_state_r;
    dst_load_s  = 1'b0;
    dst_pop_s   = 1'b0;
    case (dst_state_r)
      D_EMPTY: begin
        if (req_edge_s) begin
          dst_load_s  = 1'b1;
          dst_state_s = D_FULL;
        end else begin
          dst_state_s = D_EMPTY;
        end
      end
      D_FULL: begin
        if (dst_ready) begin
          dst_pop_s   = 1'b1;
          dst_state_s = D_EMPTY;
        end else begin
          dst_state_s = D_FULL;
        end
      end
      default: dst_state_s = D_EMPTY;
    endcase
  end

  // destination registers; hold_r is stable here because req has already settled
  always_ff @(posedge clk_b or negedge brstn) begin
    if (!brstn) begin
      dst_state_r <= D_EMPTY;
      req_d_r     <= 1'b0;
      ack_tgl_r   <= 1'b0;
      dst_valid_r <= 1'b0;
      dst_data_r  <= '0;
    end else begin
      dst_state_r <= dst_state_s;
      req_d_r     <= req_s;
      if (dst_load_s) begin
        dst_data_r  <= hold_r;
        dst_valid_r <= 1'b1;
      end else if (dst_pop_s) begin
        dst_valid_r <= 1'b0;
        ack_tgl_r   <= ~ack_tgl_r;
      end
    end
  end

  assign src_ready = src_ready_r;
  assign src_busy  = src_busy_r;
  assign dst_valid = dst_valid_r;
  assign dst_data  = dst_data_r;

endmodule

// File: tb/tb_cdc_handshake_bus.sv
// Directed bench: a 16-bit/2-stage crossing (clk_a 100 / clk_b 270 units) and a
// 4-bit/3-stage crossing (clk_c 200 / clk_d 42 units) share the two resets.
module tb_cdc_handshake_bus;

  logic clk_a = 1'b0;
  logic clk_b = 1'b0;
  logic clk_c = 1'b0;
  logic clk_d = 1'b0;
  logic arstn;
  logic brstn;

  logic [15:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] dst_data;
  logic        dst_valid;
  logic        dst_ready;
  logic        src_busy;

  logic [3:0]  c_src_data;
  logic        c_src_valid;
  logic        c_src_ready;
  logic [3:0]  c_dst_data;
  logic        c_dst_valid;
  logic        c_dst_ready;
  logic        c_src_busy;

  int checks = 0;
  int errors = 0;
  int n;
  int pn;
  int cyc;
  int rx_cnt;
  int prod_tmo;
  logic seen;

  always #50  clk_a = ~clk_a;
  always #135 clk_b = ~clk_b;
  always #100 clk_c = ~clk_c;
  always #21  clk_d = ~clk_d;

  cdc_handshake_bus #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk_a     (clk_a),
    .arstn     (arstn),
    .clk_b     (clk_b),
    .brstn     (brstn),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .dst_data  (dst_data),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .src_busy  (src_busy)
  );

  cdc_handshake_bus #(.DATA_W(4), .SYNC_STAGES(3)) dut_c (
    .clk_a     (clk_c),
    .arstn     (arstn),
    .clk_b     (clk_d),
    .brstn     (brstn),
    .src_data  (c_src_data),
    .src_valid (c_src_valid),
    .src_ready (c_src_ready),
    .dst_data  (c_dst_data),
    .dst_valid (c_dst_valid),
    .dst_ready (c_dst_ready),
    .src_busy  (c_src_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // offer one word to the 16-bit crossing; returns 1 unit after the accept edge
  task automatic send16(input logic [15:0] w);
    int k;
    k = 0;
    @(negedge clk_a);
    while (!src_ready && k < 500) begin
      @(negedge clk_a);
      k++;
    end
    chk("send16_ready_timeout", 32'(k < 500), 32'd1);
    src_data  = w;
    src_valid = 1'b1;
    @(posedge clk_a);
    #1;
    src_valid = 1'b0;
  endtask

  // wait (bounded) for the 16-bit crossing to present a word
  task automatic wait_dst16(input string tag);
    int k;
    k = 0;
    @(negedge clk_b);
    while (!dst_valid && k < 100) begin
      @(negedge clk_b);
      k++;
    end
    chk(tag, 32'(dst_valid), 32'd1);
  endtask

  initial begin
    arstn = 1'b0;  brstn = 1'b0;
    src_data = 16'h0000;  src_valid = 1'b0;  dst_ready = 1'b0;
    c_src_data = 4'h0;    c_src_valid = 1'b0; c_dst_ready = 1'b0;

    // ---------------- reset values and idle ----------------
    #333;
    chk("rst_src_ready", 32'(src_ready), 32'd1);
    chk("rst_src_busy",  32'(src_busy),  32'd0);
    chk("rst_dst_valid", 32'(dst_valid), 32'd0);
    chk("rst_dst_data",  32'(dst_data),  32'd0);
    chk("rst_c_src_ready", 32'(c_src_ready), 32'd1);
    chk("rst_c_dst_valid", 32'(c_dst_valid), 32'd0);
    @(negedge clk_a); #3;
    arstn = 1'b1;  brstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_b); #1;
      seen = seen | dst_valid | c_dst_valid;
    end
    chk("idle_no_pulse",   32'(seen),        32'd0);
    chk("idle_src_ready",  32'(src_ready),   32'd1);
    chk("idle_src_busy",   32'(src_busy),    32'd0);
    chk("idle_dst_data",   32'(dst_data),    32'd0);
    chk("idle_c_src_busy", 32'(c_src_busy),  32'd0);
    chk("idle_c_dst_data", 32'(c_dst_data),  32'd0);

    // ---------------- single word, latency both ways ----------------
    dst_ready = 1'b1;
    send16(16'h000A);
    chk("busy_after_accept", 32'(src_busy), 32'd1);
    n = 0;
    do begin
      @(posedge clk_b); #1; n++;
    end while (!dst_valid && n < 50);
    chk("lat_a2b",  32'(n),        32'd3);
    chk("data_0A",  32'(dst_data), 32'h000A);
    @(posedge clk_b); #1;
    chk("pulse_one_cycle", 32'(dst_valid), 32'd0);
    n = 0;
    do begin
      @(posedge clk_a); #1; n++;
    end while (!src_ready && n < 50);
    chk("lat_b2a", 32'(n), 32'd3);
    chk("busy_cleared", 32'(src_busy), 32'd0);

    // ---------------- 256-word stream, random dst_ready ----------------
    rx_cnt = 0;
    prod_tmo = 0;
    dst_ready = 1'b0;
    fork
      begin
        src_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
          src_data = 16'(i);
          pn = 0;
          @(negedge clk_a);
          while (!src_ready && pn < 500) begin
            @(negedge clk_a);
            pn++;
          end
          if (pn >= 500) prod_tmo++;
          @(posedge clk_a); #1;
        end
        src_valid = 1'b0;
      end
      begin
        cyc = 0;
        while (rx_cnt < 256 && cyc < 30000) begin
          @(negedge clk_b);
          cyc++;
          dst_ready = 1'($urandom_range(1, 0));
          if (dst_valid && dst_ready) begin
            chk("stream_data", 32'(dst_data), 32'(rx_cnt));
            rx_cnt++;
          end
        end
      end
    join
    chk("stream_count", 32'(rx_cnt), 32'd256);
    chk("stream_src_timeout", 32'(prod_tmo), 32'd0);
    @(posedge clk_b); #1;
    dst_ready = 1'b1;
    chk("stream_popped", 32'(dst_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_b); #1;
      seen = seen | dst_valid;
    end
    chk("stream_no_extra", 32'(seen), 32'd0);
    chk("stream_src_ready", 32'(src_ready), 32'd1);

    // ---------------- destination backpressure ----------------
    dst_ready = 1'b0;
    send16(16'h1234);
    wait_dst16("bp_valid_timeout");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_b);
      chk("bp_dst_data",  32'(dst_data),  32'h1234);
      chk("bp_dst_valid", 32'(dst_valid), 32'd1);
      chk("bp_src_ready", 32'(src_ready), 32'd0);
      @(negedge clk_a);
      src_valid = ~src_valid;
      src_data  = 16'hBEEF;
    end
    src_valid = 1'b0;
    @(negedge clk_b);
    dst_ready = 1'b1;
    @(posedge clk_b); #1;
    chk("bp_popped", 32'(dst_valid), 32'd0);
    n = 0;
    while (!src_ready && n < 50) begin
      @(posedge clk_a); #1; n++;
    end
    chk("bp_src_ready_back", 32'(src_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_b); #1;
      seen = seen | dst_valid;
    end
    chk("bp_ignored_valid", 32'(seen), 32'd0);

    // ---------------- 3-stage crossing, fast destination ----------------
    c_dst_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      n = 0;
      @(negedge clk_c);
      while (!c_src_ready && n < 100) begin
        @(negedge clk_c); n++;
      end
      c_src_data  = (w == 0) ? 4'hA : 4'h5;
      c_src_valid = 1'b1;
      @(posedge clk_c); #1;
      c_src_valid = 1'b0;
      n = 0;
      do begin
        @(posedge clk_d); #1; n++;
      end while (!c_dst_valid && n < 50);
      chk("c_lat_a2b", 32'(n), 32'd4);
      chk("c_data", 32'(c_dst_data), (w == 0) ? 32'hA : 32'h5);
      @(posedge clk_d); #1;
      chk("c_pulse_one_cycle", 32'(c_dst_valid), 32'd0);
      n = 0;
      do begin
        @(posedge clk_c); #1; n++;
      end while (!c_src_ready && n < 50);
      chk("c_lat_b2a", 32'(n), 32'd4);
    end

    // ---------------- overlapping reset mid-transfer ----------------
    dst_ready = 1'b0;
    send16(16'h0005);
    wait_dst16("mid_valid_timeout");
    chk("mid_data_5", 32'(dst_data), 32'h0005);
    @(negedge clk_a); #3;
    arstn = 1'b0;  brstn = 1'b0;
    #1;
    chk("mid_rst_src_ready", 32'(src_ready), 32'd1);
    chk("mid_rst_dst_valid", 32'(dst_valid), 32'd0);
    chk("mid_rst_dst_data",  32'(dst_data),  32'd0);
    repeat (3) @(negedge clk_a);
    #3;
    arstn = 1'b1;  brstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_b); #1;
      seen = seen | dst_valid;
    end
    chk("mid_no_spurious", 32'(seen), 32'd0);
    chk("mid_src_ready",   32'(src_ready), 32'd1);
    dst_ready = 1'b1;
    send16(16'h0006);
    wait_dst16("mid_next_timeout");
    chk("mid_data_6", 32'(dst_data), 32'h0006);
    @(posedge clk_b); #1;
    chk("mid_popped", 32'(dst_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
